tl_ul_client_bridge: RTL and testbench
======================================

# tl_ul_client_bridge

Parametrised TileLink-UL client bridge between the core's simple load/store request port and a TL-UL Channel A/D link. Issues Get/PutFullData/PutPartialData with up to NUM_OUTSTANDING transactions in flight, one source ID per reorder slot. Accepts Channel D responses in any order and returns them to the requester in issue order. Flags protocol violations on Channel D.

## Interface
- DATA_WIDTH, 32: data bus width; one of 32/64/128.
- ADDR_WIDTH, 32: address width.
- SOURCE_WIDTH, 2: a_source/d_source width.
- NUM_OUTSTANDING, 4: reorder slots; 1..2**SOURCE_WIDTH.
- SIZE_WIDTH, 3: a_size/d_size width.
- Ports (clock and reset first):
  - clk  in  1  sole clock.
  - reset  in  1  asynchronous, active-high reset.
  - req_valid / req_ready  in / out  1  request handshake.
  - req_we  in  1  1 = write.
  - req_addr  in  ADDR_WIDTH  byte address.
  - req_size  in  SIZE_WIDTH  log2 bytes; ≤ log2(DATA_WIDTH/8).
  - req_wdata  in  DATA_WIDTH  write data.
  - req_wstrb  in  DATA_WIDTH/8  byte lanes; also used as the Get mask.
  - rsp_valid / rsp_ready  out / in  1  response handshake.
  - rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
  - rsp_err  out  1  d_denied or d_corrupt seen for this transaction.
  - Channel A outputs: a_opcode[2:0], a_param[2:0], a_size, a_source, a_address, a_mask, a_data, a_corrupt, a_valid. Input: a_ready.
  - Channel D inputs: d_opcode[2:0], d_param[1:0], d_size, d_source, d_sink, d_denied, d_data, d_corrupt, d_valid. Output: d_ready.
  - outstanding  out  $clog2(NUM_OUTSTANDING+1)  allocated slots.
  - proto_err  out  1  sticky Channel D violation flag.

## Operation
- Slot state per entry: EMPTY → ISSUED (on request accept) → DONE (on D beat) → EMPTY (on response handshake).
- tail pointer allocates slots; head pointer retires them. Both wrap modulo NUM_OUTSTANDING. a_source = allocated slot index.
- Opcode selection:
  - !req_we → Get (4).
  - req_we with wstrb all ones → PutFullData (0).
  - Otherwise → PutPartialData (1).
  - Opcode is recorded in the slot. a_param = 0, a_corrupt = 0.
- req_ready = (!a_valid || a_ready) && outstanding < NUM_OUTSTANDING.
  - A retire in the same cycle does not free the slot for that cycle's accept.
- A D beat with d_valid and d_ready is checked against slot s = d_source.
  - Accepted when s < NUM_OUTSTANDING, slot s is ISSUED, and d_opcode is the expected response: AccessAckData (1) for Get, AccessAck (0) for Put.
  - On accept: store d_data (Get only), set err = d_denied | d_corrupt, and move the slot to DONE.
  - Any other D beat: set proto_err, drop the beat, leave slot state unchanged.
- rsp_valid = (slot[head] == DONE). rsp_rdata and rsp_err come from slot[head].
  - On handshake: slot → EMPTY, head++.
- outstanding: +1 on accept, −1 on retire, unchanged when both occur in the same cycle.
- Only single-beat transfers are supported. req_size larger than the bus width is illegal; behaviour is undefined and no check is made.

## Timing
- Reset (asynchronous):
  - Outputs: a_valid=0, rsp_valid=0, d_ready=0, proto_err=0, outstanding=0. All A fields 0.
  - Internal: all slots EMPTY, head = tail = 0.
  - d_ready rises to 1 on the first clk edge after reset deasserts and stays 1.
- A channel is registered. Request accepted at edge t → a_valid high after t.
  - a_valid and A fields hold while !a_ready.
  - Back-to-back accepts are allowed when a_ready=1.
- D beat accepted at edge t → rsp_valid after t if that slot is head.
  - Otherwise the slot waits DONE until it reaches head.
- rsp_valid and rsp fields hold until rsp_ready.
- proto_err is sticky until reset.
- Reset mid-operation discards all slots; in-flight D beats arriving during reset are ignored.

## Structure
- riscv_protocol_types_pkg additions:
  - TL A opcode constants: GET, PUT_FULL, PUT_PARTIAL.
  - TL D opcode constants: ACCESS_ACK, ACCESS_ACK_DATA.
  - tl_slot_state_e {EMPTY, ISSUED, DONE}.
- One sub-module, tl_ul_reorder_buf. It holds the slot state, opcode, data and err arrays, the head/tail pointers and the outstanding counter.
- The top level owns the A output register, opcode selection and D checking.

## Test plan
- Single read: req Get at 0x1000, D AccessAckData source 0 data 0xDEADBEEF → a_opcode=4, a_source=0; rsp_rdata=0xDEADBEEF, rsp_err=0 one cycle after the D beat.
- Partial write: wstrb=0b0011 → a_opcode=1, a_mask=0b0011. wstrb=0b1111 → a_opcode=0. AccessAck → rsp_rdata=0, rsp_err=0.
- Reorder: issue 4 Gets with sources 0–3; D returns 3,1,0,2 → responses come out in source order 0,1,2,3 with matching data. req_ready=0 while outstanding=4.
- Violations: D with source 2 while slot 2 EMPTY, then AccessAck to a Get → proto_err=1 and stays 1; no rsp_valid.
- Backpressure: hold a_ready=0 for 5 cycles → A fields stable and req_ready=0. Hold rsp_ready=0 → rsp stable and outstanding not decremented.
- Reset mid-operation: assert reset with 3 outstanding → a_valid, rsp_valid and outstanding are 0 immediately; after release, a new Get is issued with source 0.

Source files
------------

// File: rtl/riscv_protocol_types_pkg.sv
// TileLink-UL opcode constants and reorder slot state
// shared by the client bridge and its reorder buffer.
package riscv_protocol_types_pkg;

  localparam logic [2:0] PUT_FULL        = 3'd0;
  localparam logic [2:0] PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] GET             = 3'd4;
  localparam logic [2:0] ACCESS_ACK      = 3'd0;
  localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

  typedef enum logic [1:0] {
    EMPTY,
    ISSUED,
    DONE
  } tl_slot_state_e;

  function automatic logic [2:0] tl_a_opcode(
    input logic we,
    input logic full
  );
    if (!we) return GET;
    return full ? PUT_FULL : PUT_PARTIAL;
  endfunction

  function automatic logic [2:0] tl_d_expect(input logic [2:0] a_op);
    return (a_op == GET) ? ACCESS_ACK_DATA : ACCESS_ACK;
  endfunction

endpackage

// File: rtl/tl_ul_reorder_buf.sv
// Reorder slots for the TL-UL client bridge: allocation in issue
// order, completion in any order, retirement in issue order.
module tl_ul_reorder_buf
  import riscv_protocol_types_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int SOURCE_WIDTH    = 2,
  parameter int NUM_OUTSTANDING = 4,
  localparam int IW = (NUM_OUTSTANDING > 1) ? $clog2(NUM_OUTSTANDING) : 1,
  localparam int CW = $clog2(NUM_OUTSTANDING + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    alloc_i,
  input  logic [2:0]              alloc_op_i,
  output logic [IW-1:0]           tail_o,
  output logic                    full_o,
  input  logic [SOURCE_WIDTH-1:0] look_src_i,
  output logic                    look_hit_o,
  output logic [2:0]              look_op_o,
  input  logic                    done_i,
  input  logic [DATA_WIDTH-1:0]   done_data_i,
  input  logic                    done_err_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic [CW-1:0]           outstanding_o
);

  tl_slot_state_e        slot_q [NUM_OUTSTANDING];
  logic [2:0]            op_q   [NUM_OUTSTANDING];
  logic [DATA_WIDTH-1:0] data_q [NUM_OUTSTANDING];
  logic                  err_q  [NUM_OUTSTANDING];
  logic [IW-1:0]         head_q, tail_q;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx;
  logic                  in_range, retire;

  function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
    return (p == IW'(NUM_OUTSTANDING - 1)) ? '0 : p + IW'(1);
  endfunction

  assign in_range = {1'b0, look_src_i} < (SOURCE_WIDTH + 1)'(NUM_OUTSTANDING);
  assign idx      = IW'(look_src_i);

  assign look_hit_o = in_range && (slot_q[idx] == ISSUED);
  assign look_op_o  = op_q[idx];

  assign rsp_valid_o   = (slot_q[head_q] == DONE);
  assign rsp_rdata_o   = data_q[head_q];
  assign rsp_err_o     = err_q[head_q];
  assign retire        = rsp_valid_o && rsp_ready_i;
  assign tail_o        = tail_q;
  assign full_o        = (cnt_q == CW'(NUM_OUTSTANDING));
  assign outstanding_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (alloc_i && !retire) cnt_d = cnt_q + CW'(1);
    if (!alloc_i && retire) cnt_d = cnt_q - CW'(1);
  end

  // alloc, done and retire always touch distinct slots (EMPTY/ISSUED/DONE)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_OUTSTANDING; i++) begin
        slot_q[i] <= EMPTY;
        op_q[i]   <= '0;
        data_q[i] <= '0;
        err_q[i]  <= 1'b0;
      end
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (alloc_i) begin
        slot_q[tail_q] <= ISSUED;
        op_q[tail_q]   <= alloc_op_i;
        tail_q         <= ptr_inc(tail_q);
      end
      if (done_i) begin
        slot_q[idx] <= DONE;
        data_q[idx] <= (op_q[idx] == GET) ? done_data_i : '0;
        err_q[idx]  <= done_err_i;
      end
      if (retire) begin
        slot_q[head_q] <= EMPTY;
        head_q         <= ptr_inc(head_q);
      end
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tl_ul_client_bridge.sv
// TL-UL client bridge: registered Channel A issue, Channel D
// checking, in-order responses through the reorder buffer.
module tl_ul_client_bridge
  import riscv_protocol_types_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int SOURCE_WIDTH    = 2,
  parameter int NUM_OUTSTANDING = 4,
  parameter int SIZE_WIDTH      = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [SIZE_WIDTH-1:0]   req_size,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic [2:0]              a_opcode,
  output logic [2:0]              a_param,
  output logic [SIZE_WIDTH-1:0]   a_size,
  output logic [SOURCE_WIDTH-1:0] a_source,
  output logic [ADDR_WIDTH-1:0]   a_address,
  output logic [DATA_WIDTH/8-1:0] a_mask,
  output logic [DATA_WIDTH-1:0]   a_data,
  output logic                    a_corrupt,
  output logic                    a_valid,
  input  logic                    a_ready,
  input  logic [2:0]              d_opcode,
  input  logic [1:0]              d_param,
  input  logic [SIZE_WIDTH-1:0]   d_size,
  input  logic [SOURCE_WIDTH-1:0] d_source,
  input  logic                    d_sink,
  input  logic                    d_denied,
  input  logic [DATA_WIDTH-1:0]   d_data,
  input  logic                    d_corrupt,
  input  logic                    d_valid,
  output logic                    d_ready,
  output logic [$clog2(NUM_OUTSTANDING+1)-1:0] outstanding,
  output logic                    proto_err
);

  localparam int IW = (NUM_OUTSTANDING > 1) ? $clog2(NUM_OUTSTANDING) : 1;

  logic                    a_valid_q;
  logic [2:0]              a_opcode_q;
  logic [SIZE_WIDTH-1:0]   a_size_q;
  logic [SOURCE_WIDTH-1:0] a_source_q;
  logic [ADDR_WIDTH-1:0]   a_address_q;
  logic [DATA_WIDTH/8-1:0] a_mask_q;
  logic [DATA_WIDTH-1:0]   a_data_q;
  logic                    d_ready_q;
  logic                    proto_err_q, proto_err_d;

  logic [IW-1:0] tail;
  logic          full, accept, look_hit;
  logic [2:0]    look_op;
  logic          d_fire, d_ok;
  logic          unused_d;

  assign unused_d = ^{d_param, d_size, d_sink};

  assign req_ready = (!a_valid_q || a_ready) && !full;
  assign accept    = req_valid && req_ready;

  assign d_fire = d_valid && d_ready_q;
  assign d_ok   = look_hit && (d_opcode == tl_d_expect(look_op));

  assign proto_err_d = proto_err_q | (d_fire & ~d_ok);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_valid_q   <= 1'b0;
      a_opcode_q  <= '0;
      a_size_q    <= '0;
      a_source_q  <= '0;
      a_address_q <= '0;
      a_mask_q    <= '0;
      a_data_q    <= '0;
      d_ready_q   <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      d_ready_q   <= 1'b1;
      proto_err_q <= proto_err_d;
      if (accept) begin
        a_valid_q   <= 1'b1;
        a_opcode_q  <= tl_a_opcode(req_we, &req_wstrb);
        a_size_q    <= req_size;
        a_source_q  <= SOURCE_WIDTH'(tail);
        a_address_q <= req_addr;
        a_mask_q    <= req_wstrb;
        a_data_q    <= req_wdata;
      end else if (a_ready) begin
        a_valid_q <= 1'b0;
      end
    end
  end

  tl_ul_reorder_buf #(
    .DATA_WIDTH      (DATA_WIDTH),
    .SOURCE_WIDTH    (SOURCE_WIDTH),
    .NUM_OUTSTANDING (NUM_OUTSTANDING)
  ) u_rob (
    .clk           (clk),
    .reset         (reset),
    .alloc_i       (accept),
    .alloc_op_i    (tl_a_opcode(req_we, &req_wstrb)),
    .tail_o        (tail),
    .full_o        (full),
    .look_src_i    (d_source),
    .look_hit_o    (look_hit),
    .look_op_o     (look_op),
    .done_i        (d_fire && d_ok),
    .done_data_i   (d_data),
    .done_err_i    (d_denied | d_corrupt),
    .rsp_valid_o   (rsp_valid),
    .rsp_ready_i   (rsp_ready),
    .rsp_rdata_o   (rsp_rdata),
    .rsp_err_o     (rsp_err),
    .outstanding_o (outstanding)
  );

  assign a_valid   = a_valid_q;
  assign a_opcode  = a_opcode_q;
  assign a_param   = 3'd0;
  assign a_size    = a_size_q;
  assign a_source  = a_source_q;
  assign a_address = a_address_q;
  assign a_mask    = a_mask_q;
  assign a_data    = a_data_q;
  assign a_corrupt = 1'b0;
  assign d_ready   = d_ready_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_tl_ul_client_bridge.sv
// Bench for tl_ul_client_bridge: directed scenarios plus a randomized
// run checked against an issue-order transaction model.
module tb_tl_ul_client_bridge;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [2:0]  req_size = '0;
  logic [3:0]  req_wstrb = '0;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_err;
  logic [31:0] rsp_rdata;
  logic [2:0]  a_opcode, a_param, a_size;
  logic [1:0]  a_source;
  logic [31:0] a_address, a_data;
  logic [3:0]  a_mask;
  logic        a_corrupt, a_valid, a_ready = 1'b1;
  logic [2:0]  d_opcode = '0, d_size = '0;
  logic [1:0]  d_param = '0, d_source = '0;
  logic        d_sink = 1'b0, d_denied = 1'b0, d_corrupt = 1'b0;
  logic        d_valid = 1'b0, d_ready;
  logic [31:0] d_data = '0;
  logic [2:0]  outstanding;
  logic        proto_err;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  src;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
    logic [2:0]  size;
  } abeat_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } req_t;

  abeat_t a_log[$];
  rsp_t   r_log[$];

  always #5 clk = ~clk;

  tl_ul_client_bridge dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
    .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .a_opcode(a_opcode), .a_param(a_param), .a_size(a_size),
    .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
    .a_data(a_data), .a_corrupt(a_corrupt), .a_valid(a_valid),
    .a_ready(a_ready),
    .d_opcode(d_opcode), .d_param(d_param), .d_size(d_size),
    .d_source(d_source), .d_sink(d_sink), .d_denied(d_denied),
    .d_data(d_data), .d_corrupt(d_corrupt), .d_valid(d_valid),
    .d_ready(d_ready),
    .outstanding(outstanding), .proto_err(proto_err)
  );

  always @(negedge clk) begin
    if (!reset) begin
      if (a_valid && a_ready)
        a_log.push_back('{a_opcode, a_source, a_address, a_mask, a_data, a_size});
      if (rsp_valid && rsp_ready)
        r_log.push_back('{rsp_rdata, rsp_err});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0;
    d_valid = 1'b0;
    a_ready = 1'b1;
    rsp_ready = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    a_log.delete();
    r_log.delete();
  endtask

  task automatic issue(input logic we, input logic [31:0] addr,
                       input logic [2:0] sz, input logic [3:0] st,
                       input logic [31:0] wd);
    bit got = 0;
    req_we = we; req_addr = addr; req_size = sz;
    req_wstrb = st; req_wdata = wd; req_valid = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = req_ready;
      tick();
    end
    req_valid = 1'b0;
    total++;
    if (!got) begin
      bad++; $display("FAIL issue_timeout got=no-accept want=accept");
    end
  endtask

  task automatic send_d(input logic [1:0] src, input logic [2:0] op,
                        input logic [31:0] dat, input logic den,
                        input logic cor);
    d_source = src; d_opcode = op; d_data = dat;
    d_denied = den; d_corrupt = cor; d_valid = 1'b1;
    @(negedge clk);
    total++;
    if (d_ready !== 1'b1) begin
      bad++; $display("FAIL d_ready got=%0b want=1", d_ready);
    end
    tick();
    d_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    total++; if (a_valid !== 1'b0) begin bad++; $display("FAIL rst_a_valid got=%0b want=0", a_valid); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%0b want=0", rsp_valid); end
    total++; if (d_ready !== 1'b0) begin bad++; $display("FAIL rst_d_ready got=%0b want=0", d_ready); end
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL rst_proto_err got=%0b want=0", proto_err); end
    total++; if (outstanding !== 3'd0) begin bad++; $display("FAIL rst_outstanding got=%0d want=0", outstanding); end
    total++;
    if ({a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt} !== '0) begin
      bad++; $display("FAIL rst_a_fields got=%0h want=0", a_address);
    end
    reset = 1'b0;
    #1;
    total++; if (d_ready !== 1'b0) begin bad++; $display("FAIL rel_d_ready got=%0b want=0", d_ready); end
    tick();
    total++; if (d_ready !== 1'b1) begin bad++; $display("FAIL post_d_ready got=%0b want=1", d_ready); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL post_req_ready got=%0b want=1", req_ready); end
    a_log.delete();
    r_log.delete();
  endtask

  task automatic test_single_read();
    do_reset();
    issue(1'b0, 32'h1000, 3'd2, 4'hF, 32'h0);
    total++; if (a_valid !== 1'b1) begin bad++; $display("FAIL rd_a_valid got=%0b want=1", a_valid); end
    total++; if (a_opcode !== 3'd4) begin bad++; $display("FAIL rd_a_opcode got=%0d want=4", a_opcode); end
    total++; if (a_source !== 2'd0) begin bad++; $display("FAIL rd_a_source got=%0d want=0", a_source); end
    total++; if (a_address !== 32'h1000) begin bad++; $display("FAIL rd_a_address got=%0h want=1000", a_address); end
    send_d(2'd0, 3'd1, 32'hDEADBEEF, 1'b0, 1'b0);
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL rd_rsp_valid got=%0b want=1", rsp_valid); end
    total++; if (rsp_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_rdata got=%0h want=deadbeef", rsp_rdata); end
    total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL rd_err got=%0b want=0", rsp_err); end
    total++; if (outstanding !== 3'd1) begin bad++; $display("FAIL rd_outst got=%0d want=1", outstanding); end
    tick();
    total++; if (outstanding !== 3'd0) begin bad++; $display("FAIL rd_outst_done got=%0d want=0", outstanding); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rd_rsp_drop got=%0b want=0", rsp_valid); end
  endtask

  task automatic test_partial_write();
    do_reset();
    issue(1'b1, 32'h2000, 3'd1, 4'b0011, 32'h11223344);
    total++; if (a_opcode !== 3'd1) begin bad++; $display("FAIL pw_opcode got=%0d want=1", a_opcode); end
    total++; if (a_mask !== 4'b0011) begin bad++; $display("FAIL pw_mask got=%0h want=3", a_mask); end
    total++; if (a_data !== 32'h11223344) begin bad++; $display("FAIL pw_data got=%0h want=11223344", a_data); end
    issue(1'b1, 32'h2004, 3'd2, 4'hF, 32'hCAFEF00D);
    total++; if (a_opcode !== 3'd0) begin bad++; $display("FAIL fw_opcode got=%0d want=0", a_opcode); end
    total++; if (a_source !== 2'd1) begin bad++; $display("FAIL fw_source got=%0d want=1", a_source); end
    send_d(2'd0, 3'd0, 32'hFFFFFFFF, 1'b0, 1'b0);
    total++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      bad++; $display("FAIL pw_rsp got=%0b/%0h/%0b want=1/0/0", rsp_valid, rsp_rdata, rsp_err);
    end
    send_d(2'd1, 3'd0, 32'h12345678, 1'b1, 1'b0);
    total++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0 || rsp_err !== 1'b1) begin
      bad++; $display("FAIL fw_rsp got=%0b/%0h/%0b want=1/0/1", rsp_valid, rsp_rdata, rsp_err);
    end
    tick();
    total++; if (outstanding !== 3'd0) begin bad++; $display("FAIL pw_outst got=%0d want=0", outstanding); end
  endtask

  task automatic test_reorder();
    logic [31:0] dat [4];
    int order [4] = '{3, 1, 0, 2};
    rsp_t r;
    abeat_t b;
    do_reset();
    for (int i = 0; i < 4; i++) dat[i] = $urandom;
    for (int i = 0; i < 4; i++) issue(1'b0, 32'h100 * i, 3'd2, 4'hF, 32'h0);
    @(negedge clk);
    total++; if (outstanding !== 3'd4) begin bad++; $display("FAIL ro_outst got=%0d want=4", outstanding); end
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL ro_req_ready got=%0b want=0", req_ready); end
    tick();
    total++; if (a_log.size() != 4) begin bad++; $display("FAIL ro_a_count got=%0d want=4", a_log.size()); end
    for (int i = 0; i < 4 && a_log.size() > 0; i++) begin
      b = a_log.pop_front();
      total++;
      if (b.src !== 2'(i) || b.op !== 3'd4) begin
        bad++; $display("FAIL ro_a_src[%0d] got=%0d/%0d want=%0d/4", i, b.src, b.op, i);
      end
    end
    for (int k = 0; k < 4; k++) begin
      send_d(2'(order[k]), 3'd1, dat[order[k]], 1'b0, 1'b0);
      if (k < 2) begin
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL ro_early_rsp k=%0d got=%0b want=0", k, rsp_valid); end
      end
    end
    for (int i = 0; i < 4; i++) tick();
    total++; if (r_log.size() != 4) begin bad++; $display("FAIL ro_rsp_count got=%0d want=4", r_log.size()); end
    for (int i = 0; i < 4 && r_log.size() > 0; i++) begin
      r = r_log.pop_front();
      total++;
      if (r.rdata !== dat[i] || r.err !== 1'b0) begin
        bad++; $display("FAIL ro_rsp[%0d] got=%0h/%0b want=%0h/0", i, r.rdata, r.err, dat[i]);
      end
    end
  endtask

  task automatic test_violations();
    do_reset();
    send_d(2'd2, 3'd0, 32'h0, 1'b0, 1'b0);
    total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL vio_empty got=%0b want=1", proto_err); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL vio_empty_rsp got=%0b want=0", rsp_valid); end
    issue(1'b0, 32'h40, 3'd2, 4'hF, 32'h0);
    send_d(2'd0, 3'd0, 32'h55, 1'b0, 1'b0);
    total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL vio_opcode got=%0b want=1", proto_err); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL vio_opcode_rsp got=%0b want=0", rsp_valid); end
    total++; if (outstanding !== 3'd1) begin bad++; $display("FAIL vio_outst got=%0d want=1", outstanding); end
    send_d(2'd0, 3'd1, 32'h600DF00D, 1'b0, 1'b1);
    total++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h600DF00D || rsp_err !== 1'b1) begin
      bad++; $display("FAIL vio_good_rsp got=%0b/%0h/%0b want=1/600df00d/1", rsp_valid, rsp_rdata, rsp_err);
    end
    tick();
    total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL vio_sticky got=%0b want=1", proto_err); end
  endtask

  task automatic test_backpressure();
    logic [45:0] snap;
    logic [31:0] dv;
    do_reset();
    dv = $urandom;
    a_ready = 1'b0;
    issue(1'b0, 32'h3000, 3'd2, 4'hF, 32'h0);
    snap = {a_opcode, a_size, a_source, a_address, a_mask};
    req_we = 1'b1; req_addr = 32'h3004; req_wstrb = 4'b0101;
    req_wdata = 32'hA5A5A5A5; req_size = 3'd2; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (a_valid !== 1'b1 || req_ready !== 1'b0 ||
          {a_opcode, a_size, a_source, a_address, a_mask} !== snap) begin
        bad++; $display("FAIL bp_hold[%0d] got=%0b/%0b/%0h want=1/0/%0h", i, a_valid, req_ready, a_address, snap);
      end
      tick();
    end
    a_ready = 1'b1;
    @(negedge clk);
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=%0b want=1", req_ready); end
    tick();
    req_valid = 1'b0;
    total++; if (a_source !== 2'd1 || a_opcode !== 3'd1 || a_mask !== 4'b0101) begin
      bad++; $display("FAIL bp_second got=%0d/%0d/%0h want=1/1/5", a_source, a_opcode, a_mask);
    end
    rsp_ready = 1'b0;
    send_d(2'd0, 3'd1, dv, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== dv || outstanding !== 3'd2) begin
        bad++; $display("FAIL bp_rsp_hold[%0d] got=%0b/%0h/%0d want=1/%0h/2", i, rsp_valid, rsp_rdata, outstanding, dv);
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    total++; if (outstanding !== 3'd1 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL bp_retire got=%0d/%0b want=1/0", outstanding, rsp_valid);
    end
    send_d(2'd1, 3'd0, 32'h0, 1'b0, 1'b0);
    tick();
    total++; if (outstanding !== 3'd0) begin bad++; $display("FAIL bp_drain got=%0d want=0", outstanding); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) issue(1'b0, 32'h500 + 32'(4 * i), 3'd2, 4'hF, 32'h0);
    send_d(2'd1, 3'd1, 32'h77, 1'b0, 1'b0);
    d_source = 2'd0; d_opcode = 3'd1; d_data = 32'h99; d_valid = 1'b1;
    reset = 1'b1;
    #1;
    total++; if (a_valid !== 1'b0 || rsp_valid !== 1'b0 || outstanding !== 3'd0) begin
      bad++; $display("FAIL mid_rst got=%0b/%0b/%0d want=0/0/0", a_valid, rsp_valid, outstanding);
    end
    tick();
    tick();
    d_valid = 1'b0;
    reset = 1'b0;
    tick();
    a_log.delete();
    r_log.delete();
    total++; if (rsp_valid !== 1'b0 || outstanding !== 3'd0 || d_ready !== 1'b1) begin
      bad++; $display("FAIL mid_post got=%0b/%0d/%0b want=0/0/1", rsp_valid, outstanding, d_ready);
    end
    issue(1'b0, 32'h600, 3'd2, 4'hF, 32'h0);
    total++; if (a_source !== 2'd0 || a_opcode !== 3'd4) begin
      bad++; $display("FAIL mid_new got=%0d/%0d want=0/4", a_source, a_opcode);
    end
    send_d(2'd0, 3'd1, 32'h1, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_random();
    int nreq = 200;
    int sent = 0, acc = 0, aseen = 0, rchk = 0, rdone = 0;
    int j, k;
    bit took;
    req_t mq[$];
    req_t r;
    int pend[$];
    logic [31:0] exp_rd [256];
    logic exp_er [256];
    logic [2:0] eop;
    abeat_t b;
    rsp_t rr;
    do_reset();
    for (int cyc = 0; cyc < 6000 && rchk < nreq; cyc++) begin
      if (!req_valid && sent < nreq && $urandom_range(0, 1) == 1) begin
        r.we = 1'($urandom_range(0, 1));
        r.addr = $urandom;
        r.size = 3'($urandom_range(0, 2));
        r.strb = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
        r.wdata = $urandom;
        mq.push_back(r);
        req_we = r.we; req_addr = r.addr; req_size = r.size;
        req_wstrb = r.strb; req_wdata = r.wdata; req_valid = 1'b1;
        sent++;
      end
      a_ready = ($urandom_range(0, 3) != 0);
      rsp_ready = ($urandom_range(0, 9) < 7);
      if (pend.size() > 0 && $urandom_range(0, 2) != 0) begin
        j = $urandom_range(0, pend.size() - 1);
        k = pend[j];
        pend.delete(j);
        exp_rd[k] = mq[k].we ? 32'h0 : $urandom;
        d_denied = ($urandom_range(0, 7) == 0);
        d_corrupt = ($urandom_range(0, 7) == 0);
        exp_er[k] = d_denied | d_corrupt;
        d_source = 2'(k % 4);
        d_opcode = mq[k].we ? 3'd0 : 3'd1;
        d_data = mq[k].we ? $urandom : exp_rd[k];
        d_valid = 1'b1;
      end
      rdone = rchk + r_log.size();
      @(negedge clk);
      took = req_valid && req_ready;
      total++;
      if (outstanding !== 3'(acc - rdone)) begin
        bad++; $display("FAIL rnd_outst cyc=%0d got=%0d want=%0d", cyc, outstanding, acc - rdone);
      end
      tick();
      d_valid = 1'b0;
      if (took) begin
        req_valid = 1'b0;
        acc++;
      end
      while (a_log.size() > 0) begin
        b = a_log.pop_front();
        r = mq[aseen];
        eop = !r.we ? 3'd4 : ((r.strb == 4'hF) ? 3'd0 : 3'd1);
        total++;
        if (b.op !== eop || b.src !== 2'(aseen % 4) || b.addr !== r.addr ||
            b.mask !== r.strb || b.size !== r.size || (r.we && b.data !== r.wdata)) begin
          bad++;
          $display("FAIL rnd_a[%0d] got op=%0d src=%0d addr=%0h mask=%0h want op=%0d src=%0d addr=%0h mask=%0h",
                   aseen, b.op, b.src, b.addr, b.mask, eop, aseen % 4, r.addr, r.strb);
        end
        pend.push_back(aseen);
        aseen++;
      end
      while (r_log.size() > 0) begin
        rr = r_log.pop_front();
        total++;
        if (rr.rdata !== exp_rd[rchk] || rr.err !== exp_er[rchk]) begin
          bad++;
          $display("FAIL rnd_rsp[%0d] got=%0h/%0b want=%0h/%0b", rchk, rr.rdata, rr.err, exp_rd[rchk], exp_er[rchk]);
        end
        rchk++;
      end
    end
    total++;
    if (rchk != nreq) begin
      bad++; $display("FAIL rnd_timeout got=%0d want=%0d responses", rchk, nreq);
    end
    idle_inputs();
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL rnd_proto_err got=%0b want=0", proto_err); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_partial_write();
    test_reorder();
    test_violations();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
